// File: rtl/fifo_buffer_pkg.sv
// Shared defaults and the per-cycle operation encoding for the FIFO buffer.
package fifo_buffer_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_LOG2_DEPTH = 4;

  // Bit 1 = accepted write, bit 0 = accepted read.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage : fifo_buffer_pkg

// File: rtl/fifo_buffer_lutram.sv
// Distributed-RAM storage: one synchronous write port, one asynchronous read port.
module fifo_buffer_lutram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fifo_buffer_lutram

// File: rtl/fifo_buffer.sv
// Single-clock first-word-fall-through FIFO with present / half-full / full flags.
module fifo_buffer
  import fifo_buffer_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned LOG2_DEPTH = DEF_LOG2_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataPresent,
  output logic             halfFull,
  output logic             full
);

  localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;
  localparam int unsigned CW    = LOG2_DEPTH + 1;
  localparam logic [CW-1:0] HALF_CNT = CW'(DEPTH / 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_acc, rd_acc;
  fifo_op_e              op;

  assign dataPresent = (count_q != '0);
  assign halfFull    = (count_q >= HALF_CNT);
  assign full        = (count_q == FULL_CNT);

  // A write into a full FIFO is still taken when the head is popped on the same edge.
  assign wr_acc = write && (!full || read);
  assign rd_acc = read && dataPresent;
  assign op     = fifo_op_e'({wr_acc, rd_acc});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + LOG2_DEPTH'(1);
    end
    unique case (op)
      OP_PUSH: count_d = count_q + CW'(1);
      OP_POP:  count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_buffer_lutram #(
    .WIDTH (WIDTH),
    .AW    (LOG2_DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (dataIn),
    .raddr_i (rd_ptr_q),
    .rdata_o (dataOut)
  );

endmodule : fifo_buffer

// File: tb/tb_fifo_buffer.sv
// Self-checking bench for fifo_buffer against a queue-based reference model.
module tb_fifo_buffer;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned LOG2_DEPTH = 4;
  localparam int unsigned DEPTH      = 2 ** LOG2_DEPTH;

  logic             clk;
  logic             rst;
  logic             write;
  logic             read;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic             dataPresent;
  logic             halfFull;
  logic             full;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [WIDTH-1:0] model_q[$];

  fifo_buffer #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .write       (write),
    .read        (read),
    .dataIn      (dataIn),
    .dataOut     (dataOut),
    .dataPresent (dataPresent),
    .halfFull    (halfFull),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; the model is updated from its pre-edge occupancy.
  task automatic drive(input logic w, input logic r, input logic [WIDTH-1:0] d);
    bit wa, ra;
    @(negedge clk);
    write  = w;
    read   = r;
    dataIn = d;
    ra = r && (model_q.size() > 0);
    wa = w && ((model_q.size() < DEPTH) || r);
    @(posedge clk);
    if (ra) void'(model_q.pop_front());
    if (wa) model_q.push_back(d);
    #1;
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; write = 1'b0; read = 1'b0; dataIn = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dataPresent, halfFull, full} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle flags got=%b exp=000", {dataPresent, halfFull, full});
    end
    for (int unsigned i = 0; i < 10; i++) drive(1'b1, 1'b0, WIDTH'(i));
    checks++;
    if ({dataPresent, halfFull, full} !== 3'b110) begin
      errors++;
      $display("FAIL prereset_fill flags got=%b exp=110", {dataPresent, halfFull, full});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_q.delete();
    checks++;
    if ({dataPresent, halfFull, full} !== 3'b000) begin
      errors++;
      $display("FAIL reset_midfill flags got=%b exp=000", {dataPresent, halfFull, full});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 1'b0, 8'hA5);
    checks++;
    if (dataPresent !== 1'b1 || dataOut !== 8'hA5) begin
      errors++;
      $display("FAIL single_write present=%b data=%h exp present=1 data=a5", dataPresent, dataOut);
    end
    drive(1'b0, 1'b1, '0);
    checks++;
    if (dataPresent !== 1'b0) begin
      errors++;
      $display("FAIL single_read present got=%b exp=0", dataPresent);
    end
  endtask

  task automatic test_fill_drain();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, WIDTH'(i));
      checks++;
      if (halfFull !== (i + 1 >= DEPTH / 2) || full !== (i + 1 == DEPTH)) begin
        errors++;
        $display("FAIL fill_flags write=%0d half=%b full=%b exp half=%b full=%b",
                 i + 1, halfFull, full, (i + 1 >= DEPTH / 2), (i + 1 == DEPTH));
      end
    end
    drive(1'b1, 1'b0, 8'hFF);
    checks++;
    if (full !== 1'b1 || model_q.size() != DEPTH) begin
      errors++;
      $display("FAIL overflow_ignored full=%b exp=1", full);
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      checks++;
      if (dataOut !== WIDTH'(i) || dataPresent !== 1'b1) begin
        errors++;
        $display("FAIL drain_order idx=%0d data=%h exp=%h present=%b", i, dataOut, WIDTH'(i), dataPresent);
      end
      drive(1'b0, 1'b1, '0);
    end
    checks++;
    if ({dataPresent, halfFull, full} !== 3'b000) begin
      errors++;
      $display("FAIL drain_empty flags got=%b exp=000", {dataPresent, halfFull, full});
    end
    drive(1'b0, 1'b1, '0);
    checks++;
    if (dataPresent !== 1'b0) begin
      errors++;
      $display("FAIL underflow_ignored present got=%b exp=0", dataPresent);
    end
  endtask

  task automatic test_full_rw();
    logic [WIDTH-1:0] last;
    for (int unsigned i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, WIDTH'($urandom_range(0, 255)));
    drive(1'b1, 1'b1, 8'h55);
    checks++;
    if (full !== 1'b1 || model_q.size() != DEPTH) begin
      errors++;
      $display("FAIL full_rw full got=%b exp=1", full);
    end
    last = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      checks++;
      if (dataOut !== model_q[0]) begin
        errors++;
        $display("FAIL full_rw_drain idx=%0d data=%h exp=%h", i, dataOut, model_q[0]);
      end
      last = dataOut;
      drive(1'b0, 1'b1, '0);
    end
    checks++;
    if (last !== 8'h55 || dataPresent !== 1'b0) begin
      errors++;
      $display("FAIL full_rw_last data=%h exp=55 present=%b", last, dataPresent);
    end
  endtask

  task automatic test_empty_rw();
    drive(1'b1, 1'b1, 8'h3C);
    checks++;
    if (dataPresent !== 1'b1 || dataOut !== 8'h3C || halfFull !== 1'b0) begin
      errors++;
      $display("FAIL empty_rw present=%b data=%h half=%b exp present=1 data=3c half=0",
               dataPresent, dataOut, halfFull);
    end
    drive(1'b0, 1'b1, '0);
  endtask

  task automatic test_interleave();
    int unsigned written = 0;
    int unsigned popped  = 0;
    int unsigned iter    = 0;
    logic [WIDTH-1:0] sent[$];
    bit w, r;
    while ((written < 40 || model_q.size() > 0) && iter < 600) begin
      w = (written < 40) && ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 2) != 0;
      if (r && model_q.size() > 0) begin
        checks++;
        if (dataOut !== sent[popped]) begin
          errors++;
          $display("FAIL interleave_order idx=%0d data=%h exp=%h", popped, dataOut, sent[popped]);
        end
        popped++;
      end
      if (w && (model_q.size() < DEPTH || r)) begin
        sent.push_back(WIDTH'($urandom_range(0, 255)));
        written++;
        drive(1'b1, r, sent[written - 1]);
      end else begin
        drive(1'b0, r, '0);
      end
      checks++;
      if (dataPresent !== (model_q.size() != 0) || halfFull !== (model_q.size() >= DEPTH / 2) ||
          full !== (model_q.size() == DEPTH)) begin
        errors++;
        $display("FAIL interleave_flags got=%b exp=%b%b%b", {dataPresent, halfFull, full},
                 model_q.size() != 0, model_q.size() >= DEPTH / 2, model_q.size() == DEPTH);
      end
      iter++;
    end
    checks++;
    if (popped != 40 || written != 40) begin
      errors++;
      $display("FAIL interleave_count popped=%0d written=%0d exp=40", popped, written);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_rw();
    test_empty_rw();
    test_interleave();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fifo_buffer
